// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key debouncer: per-channel FSM
//                state encoding, default hold time and counter sizing helper.
//  Contents    : key_state_t        - 2-bit FSM state type
//                DB_CYCLES_DEFAULT  - default stable-hold time in clk cycles
//                cnt_width()        - debounce counter width for a hold time
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms at 10 MHz.
    localparam int unsigned DB_CYCLES_DEFAULT = 200000;

    // The counter only ever needs to reach cycles-1, so $clog2(cycles) bits
    // suffice. Clamped to 1 bit so the minimum hold time (2) stays legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_if
//  Description : Key pin / debounced event bundle between the board key pins,
//                the debouncer and the consuming control logic.
//  Signals     : key_in        - raw asynchronous key pins
//                key_state     - debounced level, 1 = pressed
//                press_pulse   - one-cycle pulse on accepted press
//                release_pulse - one-cycle pulse on accepted release
//  Modports    : master - drives key_in, observes the debounced outputs
//                slave  - the debouncer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if #(
    parameter int unsigned NUM_KEYS = 4
) ();

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;

    modport master (
        output key_in,
        input  key_state,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_in,
        output key_state,
        output press_pulse,
        output release_pulse
    );

endinterface : key_debounce_if
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One key channel: 2-FF synchronizer, polarity normalization,
//                saturating debounce counter and 4-state accept FSM with
//                registered level and pulse outputs.
//  Ports       : clk             - system clock, rising edge
//                rst_n           - asynchronous active-low reset
//                key_i           - raw asynchronous key pin
//                key_state_o     - debounced level, 1 = pressed
//                press_pulse_o   - one-cycle pulse on accepted press
//                release_pulse_o - one-cycle pulse on accepted release
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  key_i,
    output logic key_state_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int unsigned          c_cnt_w    = cnt_width(DB_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
    // Pin level of a released key; the synchronizer comes out of reset here so
    // that reset release never looks like a pin edge.
    localparam logic                 c_idle_lvl = KEY_ACTIVE_LOW;

    logic               sync1_q;
    logic               sync2_q;
    logic               w_act;
    key_state_t         state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               key_state_q;
    logic               press_q;
    logic               release_q;

    // ------------------------------------------------------------------
    // Metastability synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= c_idle_lvl;
            sync2_q <= c_idle_lvl;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // 1 = pressed regardless of board wiring.
    assign w_act = sync2_q ^ KEY_ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs. The counter restarts on every
    // entry into a WAIT state and stops at DB_CYCLES-1 because that value
    // always forces the exit transition, so it can never wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (w_act) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_act) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_q     <= PRESSED;
                        key_state_q <= 1'b1;
                        press_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_act) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_act) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_q     <= RELEASED;
                        key_state_q <= 1'b0;
                        release_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= RELEASED;
                    cnt_q       <= '0;
                    key_state_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_state_o     = key_state_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Multi-key push-button conditioner. Each key gets its own
//                synchronizer, debounce counter and FSM; all share clk.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - key_debounce_if.slave (key_in in; key_state,
//                        press_pulse, release_pulse out)
//  Parameters  : NUM_KEYS       - number of channels (must match bus)
//                DB_CYCLES      - stable hold time in clk cycles, >= 2
//                KEY_ACTIVE_LOW - 1: pressed key reads 0 on the pin
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input wire             clk,
    input wire             rst_n,
    key_debounce_if.slave  bus
);

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
            key_debounce_ch #(
                .DB_CYCLES      (DB_CYCLES),
                .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
            ) u_ch (
                .clk             (clk),
                .rst_n           (rst_n),
                .key_i           (bus.key_in[g]),
                .key_state_o     (bus.key_state[g]),
                .press_pulse_o   (bus.press_pulse[g]),
                .release_pulse_o (bus.release_pulse[g])
            );
        end
    endgenerate

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Directed self-checking bench for key_debounce. Three
//                instances: A (4 keys, DB=8, active-low), B (1 key, DB=2,
//                minimum hold, active-low), C (2 keys, DB=5000, active-high).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_key_debounce;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [3:0] acc_a_press;
    logic [3:0] acc_a_rel;
    logic [0:0] acc_b_press;
    int         c_press_n;

    key_debounce_if #(.NUM_KEYS(4)) ifa ();
    key_debounce_if #(.NUM_KEYS(1)) ifb ();
    key_debounce_if #(.NUM_KEYS(2)) ifc ();

    key_debounce #(.NUM_KEYS(4), .DB_CYCLES(8), .KEY_ACTIVE_LOW(1'b1)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
    );
    key_debounce #(.NUM_KEYS(1), .DB_CYCLES(2), .KEY_ACTIVE_LOW(1'b1)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
    );
    key_debounce #(.NUM_KEYS(2), .DB_CYCLES(5000), .KEY_ACTIVE_LOW(1'b0)) u_dut_c (
        .clk (clk), .rst_n (rst_n), .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; inputs change and outputs are sampled on negedges.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            acc_a_press = acc_a_press | ifa.press_pulse;
            acc_a_rel   = acc_a_rel   | ifa.release_pulse;
            acc_b_press = acc_b_press | ifb.press_pulse;
            c_press_n   = c_press_n + int'(ifc.press_pulse[0]);
        end
    endtask

    task automatic clear_acc();
        acc_a_press = '0;
        acc_a_rel   = '0;
        acc_b_press = '0;
    endtask

    initial begin
        clear_acc();
        c_press_n  = 0;
        rst_n      = 1'b0;
        ifa.key_in = 4'hF;
        ifb.key_in = 1'b1;
        ifc.key_in = 2'b00;

        // Reset and idle
        tick(5);
        check("rst_a_outs", {ifa.key_state, ifa.press_pulse, ifa.release_pulse}, 32'h0);
        check("rst_c_outs", {ifc.key_state, ifc.press_pulse, ifc.release_pulse}, 32'h0);
        rst_n = 1'b1;
        clear_acc();
        tick(100);
        check("idle_press", acc_a_press, 4'h0);
        check("idle_rel", acc_a_rel, 4'h0);
        check("idle_state", ifa.key_state, 4'h0);

        // Clean press/release on key0: accepted on edge 10
        ifa.key_in = 4'hE;
        tick(10);
        check("k0_press_early", {ifa.key_state, ifa.press_pulse}, 8'h00);
        tick(1);
        check("k0_press_pulse", {ifa.key_state, ifa.press_pulse}, 8'h11);
        tick(1);
        check("k0_press_end", {ifa.key_state, ifa.press_pulse}, 8'h10);
        ifa.key_in = 4'hF;
        tick(10);
        check("k0_rel_early", {ifa.key_state, ifa.release_pulse}, 8'h10);
        tick(1);
        check("k0_rel_pulse", {ifa.key_state, ifa.release_pulse}, 8'h01);
        tick(1);
        check("k0_rel_end", {ifa.key_state, ifa.release_pulse}, 8'h00);

        // Bounce: toggle every 3 cycles for 42 cycles, then settle low
        clear_acc();
        for (int i = 0; i < 14; i++) begin
            ifa.key_in[0] = ~ifa.key_in[0];
            tick(3);
        end
        check("bounce_press", acc_a_press, 4'h0);
        check("bounce_rel", acc_a_rel, 4'h0);
        check("bounce_state", ifa.key_state, 4'h0);
        ifa.key_in[0] = 1'b0;
        tick(10);
        check("settle_early", acc_a_press, 4'h0);
        tick(1);
        check("settle_pulse", {ifa.key_state, ifa.press_pulse}, 8'h11);
        clear_acc();
        tick(20);
        check("settle_single", acc_a_press, 4'h0);
        ifa.key_in = 4'hF;
        tick(15);
        check("settle_released", ifa.key_state, 4'h0);

        // Simultaneous keys 1 and 3
        ifa.key_in = 4'b0101;
        tick(11);
        check("sim_press", {ifa.key_state, ifa.press_pulse}, 8'hAA);
        tick(1);
        check("sim_press_end", ifa.press_pulse, 4'h0);
        ifa.key_in = 4'hF;
        tick(11);
        check("sim_rel", {ifa.key_state, ifa.release_pulse}, 8'h0A);

        // Reset mid-press on key2
        tick(2);
        ifa.key_in = 4'b1011;
        tick(11);
        check("k2_press", {ifa.key_state, ifa.press_pulse}, 8'h44);
        tick(5);
        clear_acc();
        rst_n = 1'b0;
        #1;
        check("k2_async_clear", {ifa.key_state, ifa.release_pulse}, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check("k2_repress_early", {ifa.key_state, ifa.press_pulse}, 8'h00);
        tick(1);
        check("k2_repress_pulse", {ifa.key_state, ifa.press_pulse}, 8'h44);
        check("k2_no_release", acc_a_rel, 4'h0);
        ifa.key_in = 4'hF;
        tick(12);

        // Minimum hold time: 1-cycle glitch rejected, press on edge 4
        ifb.key_in = 1'b0;
        tick(1);
        ifb.key_in = 1'b1;
        clear_acc();
        tick(10);
        check("b_glitch", {ifb.key_state, acc_b_press}, 2'b00);
        ifb.key_in = 1'b0;
        tick(4);
        check("b_press_early", {ifb.key_state, ifb.press_pulse}, 2'b00);
        tick(1);
        check("b_press_pulse", {ifb.key_state, ifb.press_pulse}, 2'b11);
        tick(1);
        check("b_press_end", {ifb.key_state, ifb.press_pulse}, 2'b10);
        ifb.key_in = 1'b1;
        tick(4);
        check("b_rel_early", {ifb.key_state, ifb.release_pulse}, 2'b10);
        tick(1);
        check("b_rel_pulse", {ifb.key_state, ifb.release_pulse}, 2'b01);

        // Active-high polarity, long hold: press on edge 5002
        c_press_n  = 0;
        ifc.key_in = 2'b01;
        tick(5002);
        check("c_press_early", {ifc.key_state, ifc.press_pulse}, 4'h0);
        check("c_press_early_n", c_press_n, 0);
        tick(1);
        check("c_press_pulse", {ifc.key_state, ifc.press_pulse}, 4'h5);
        tick(998);
        check("c_hold_state", {ifc.key_state, ifc.press_pulse, ifc.release_pulse}, 6'b01_00_00);
        check("c_single_pulse", c_press_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
